// File: rtl/imm_gen_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_stage_if
//  Description : Valid/ready bus between decode and the immediate stage,
//                carrying instruction, format select, tag and the
//                extended immediate result.
//  Revision    : 1.0  initial release
// ============================================================================
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      insn_i;
  logic [3:0]       imm_sel_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  imm_o;
  logic [TAG_W-1:0] tag_o;
  logic             illegal_o;

  // Producer/consumer side (drives entries in, accepts results)
  modport master (
    output in_valid_i, insn_i, imm_sel_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_o, tag_o, illegal_o
  );

  // Stage side
  modport slave (
    input  in_valid_i, insn_i, imm_sel_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_o, tag_o, illegal_o
  );
endinterface
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_stage
//  Description : Registered RV32/RV64 + RVC immediate generator with a
//                2-entry (OUT + SKID) valid/ready buffer and sync flush.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  input  wire logic         flush_i,
  imm_gen_stage_if.slave    bus
);

  // Immediate format select codes
  localparam logic [3:0] c_SEL_NONE   = 4'd0;
  localparam logic [3:0] c_SEL_I      = 4'd1;
  localparam logic [3:0] c_SEL_S      = 4'd2;
  localparam logic [3:0] c_SEL_B      = 4'd3;
  localparam logic [3:0] c_SEL_J      = 4'd4;
  localparam logic [3:0] c_SEL_U      = 4'd5;
  localparam logic [3:0] c_SEL_SHIFT  = 4'd6;
  localparam logic [3:0] c_SEL_CSR    = 4'd7;
  localparam logic [3:0] c_SEL_C_CI   = 4'd8;
  localparam logic [3:0] c_SEL_C_LWSP = 4'd9;
  localparam logic [3:0] c_SEL_C_J    = 4'd10;
  localparam logic [3:0] c_SEL_C_B    = 4'd11;

  logic [31:0]      w_insn;
  logic [63:0]      w_imm64;
  logic [XLEN-1:0]  w_imm;
  logic             w_illegal;
  logic             w_accept;
  logic             w_out_load;
  logic             w_unused;

  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_imm;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_ill;

  logic             r_skid_valid;
  logic [XLEN-1:0]  r_skid_imm;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_skid_ill;

  assign w_insn = bus.insn_i;

  // Decode is done at 64 bits and truncated, so one table serves both XLENs
  always_comb begin
    w_imm64 = '0;
    case (bus.imm_sel_i)
      c_SEL_NONE:   w_imm64 = '0;
      c_SEL_I:      w_imm64 = {{52{w_insn[31]}}, w_insn[31:20]};
      c_SEL_S:      w_imm64 = {{52{w_insn[31]}}, w_insn[31:25], w_insn[11:7]};
      c_SEL_B:      w_imm64 = {{51{w_insn[31]}}, w_insn[31], w_insn[7],
                               w_insn[30:25], w_insn[11:8], 1'b0};
      c_SEL_J:      w_imm64 = {{43{w_insn[31]}}, w_insn[31], w_insn[19:12],
                               w_insn[20], w_insn[30:21], 1'b0};
      c_SEL_U:      w_imm64 = {{32{w_insn[31]}}, w_insn[31:12], 12'b0};
      c_SEL_SHIFT:  w_imm64 = (XLEN == 64) ? {58'b0, w_insn[25:20]}
                                           : {59'b0, w_insn[24:20]};
      c_SEL_CSR:    w_imm64 = {59'b0, w_insn[19:15]};
      c_SEL_C_CI:   w_imm64 = {{58{w_insn[12]}}, w_insn[12], w_insn[6:2]};
      c_SEL_C_LWSP: w_imm64 = {56'b0, w_insn[3:2], w_insn[12], w_insn[6:4], 2'b00};
      c_SEL_C_J:    w_imm64 = {{52{w_insn[12]}}, w_insn[12], w_insn[8],
                               w_insn[10:9], w_insn[6], w_insn[7], w_insn[2],
                               w_insn[11], w_insn[5:3], 1'b0};
      c_SEL_C_B:    w_imm64 = {{55{w_insn[12]}}, w_insn[12], w_insn[6:5],
                               w_insn[2], w_insn[11:10], w_insn[4:3], 1'b0};
      default:      w_imm64 = '0;
    endcase
  end

  assign w_imm     = w_imm64[XLEN-1:0];
  // Codes 12..15 are reserved
  assign w_illegal = bus.imm_sel_i[3] & bus.imm_sel_i[2];
  // Opcode bits [1:0] never feed an immediate; upper decode bits unused at XLEN=32
  assign w_unused  = ^{w_insn[1:0], w_imm64};

  // in_ready comes straight from the SKID flag, so out_ready has no path to it
  assign w_accept   = bus.in_valid_i & ~r_skid_valid;
  assign w_out_load = ~r_out_valid | bus.out_ready_i;

  // OUT register: refill from SKID first (FIFO order), else from the input
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_out_imm   <= '0;
      r_out_tag   <= '0;
      r_out_ill   <= 1'b0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
    end else if (w_out_load) begin
      if (r_skid_valid) begin
        r_out_valid <= 1'b1;
        r_out_imm   <= r_skid_imm;
        r_out_tag   <= r_skid_tag;
        r_out_ill   <= r_skid_ill;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_imm   <= w_imm;
        r_out_tag   <= bus.tag_i;
        r_out_ill   <= w_illegal;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // SKID register: catches an accepted entry while OUT is stalled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_tag   <= '0;
      r_skid_ill   <= 1'b0;
    end else if (flush_i) begin
      r_skid_valid <= 1'b0;
    end else if (w_out_load && r_skid_valid) begin
      r_skid_valid <= 1'b0;
    end else if (w_accept && !w_out_load) begin
      r_skid_valid <= 1'b1;
      r_skid_imm   <= w_imm;
      r_skid_tag   <= bus.tag_i;
      r_skid_ill   <= w_illegal;
    end
  end

  assign bus.in_ready_o  = ~r_skid_valid;
  assign bus.out_valid_o = r_out_valid;
  assign bus.imm_o       = r_out_imm;
  assign bus.tag_o       = r_out_tag;
  assign bus.illegal_o   = r_out_ill;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_stage
//  Description : Self-checking bench for imm_gen_stage (XLEN=32 main
//                instance with scoreboard, XLEN=64 instance for widths).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imm_gen_stage;

  typedef struct packed {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic flush64 = 1'b0;
  int   checks = 0;
  int   errors = 0;
  sb_t  sb_q[$];
  sb_t  mon_e;
  logic sending;

  imm_gen_stage_if #(.XLEN(32), .TAG_W(5)) bus32();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(5)) bus64();

  imm_gen_stage #(.XLEN(32), .TAG_W(5)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus32)
  );
  imm_gen_stage #(.XLEN(64), .TAG_W(5)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush64), .bus(bus64)
  );

  always #5 clk = ~clk;

  // Reference: sign-extend the low w bits of v to 64 bits
  function automatic logic [63:0] sx(input logic [63:0] v, input int w);
    logic signed [63:0] t;
    t = $signed(v << (64 - w));
    return 64'(t >>> (64 - w));
  endfunction

  function automatic logic [63:0] model(input logic [31:0] i, input logic [3:0] sel, input int xl);
    case (sel)
      4'd1:  return sx(64'(i[31:20]), 12);
      4'd2:  return sx(64'({i[31:25], i[11:7]}), 12);
      4'd3:  return sx(64'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
      4'd4:  return sx(64'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
      4'd5:  return sx(64'({i[31:12], 12'b0}), 32);
      4'd6:  return (xl == 64) ? 64'(i[25:20]) : 64'(i[24:20]);
      4'd7:  return 64'(i[19:15]);
      4'd8:  return sx(64'({i[12], i[6:2]}), 6);
      4'd9:  return 64'({i[3:2], i[12], i[6:4], 2'b00});
      4'd10: return sx(64'({i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0}), 12);
      4'd11: return sx(64'({i[12], i[6:5], i[2], i[11:10], i[4:3], 1'b0}), 9);
      default: return 64'd0;
    endcase
  endfunction

  // Scoreboard: push on accept, pop on output transfer; reset/flush empty it
  always @(negedge clk) begin
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (bus32.out_valid_o && bus32.out_ready_i) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got tag=%0d imm=%h", bus32.tag_o, bus32.imm_o);
        end else begin
          mon_e = sb_q.pop_front();
          if ({bus32.imm_o, bus32.tag_o, bus32.illegal_o} !== {mon_e.imm[31:0], mon_e.tag, mon_e.ill}) begin
            errors++;
            $display("FAIL sb_data got imm=%h tag=%0d ill=%b exp imm=%h tag=%0d ill=%b",
                     bus32.imm_o, bus32.tag_o, bus32.illegal_o, mon_e.imm[31:0], mon_e.tag, mon_e.ill);
          end
        end
      end
      if (bus32.in_valid_i && bus32.in_ready_o)
        sb_q.push_back('{imm: model(bus32.insn_i, bus32.imm_sel_i, 32),
                         tag: bus32.tag_i, ill: (bus32.imm_sel_i >= 4'd12)});
    end
  end

  // Offer one entry and return at posedge+1 after it was accepted (in_valid left high)
  task automatic send(input logic [31:0] insn, input logic [3:0] sel, input logic [4:0] tag);
    bus32.in_valid_i = 1'b1;
    bus32.insn_i     = insn;
    bus32.imm_sel_i  = sel;
    bus32.tag_i      = tag;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus32.in_ready_o) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL send_timeout got in_ready=%b exp 1", bus32.in_ready_o);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200; n++) begin
      if (sb_q.size() == 0 && !bus32.out_valid_o) return;
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL drain_timeout got pending=%0d exp 0", sb_q.size());
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus32.out_valid_o, bus32.imm_o, bus32.tag_o, bus32.illegal_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b imm=%h tag=%0d ill=%b exp all 0",
               bus32.out_valid_o, bus32.imm_o, bus32.tag_o, bus32.illegal_o);
    end
    rst = 1'b0;
    checks++;
    if (bus32.in_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b exp 1", bus32.in_ready_o);
    end
  endtask

  task automatic test_known_values();
    logic [31:0] k_insn [6] = '{32'hFFF00093, 32'hFE000EE3, 32'h00001FFD, 32'h000050FE, 32'h00000000, 32'hFFFFFFFF};
    logic [3:0]  k_sel  [6] = '{4'd1, 4'd3, 4'd8, 4'd9, 4'd13, 4'd0};
    logic [31:0] k_imm  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h000000FC, 32'h0, 32'h0};
    logic        k_ill  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus32.out_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send(k_insn[k], k_sel[k], 5'(k + 10));
      bus32.in_valid_i = 1'b0;
      checks++;
      if (bus32.out_valid_o !== 1'b1 || bus32.imm_o !== k_imm[k] || bus32.illegal_o !== k_ill[k]) begin
        errors++;
        $display("FAIL known_%0d got v=%b imm=%h ill=%b exp v=1 imm=%h ill=%b",
                 k, bus32.out_valid_o, bus32.imm_o, bus32.illegal_o, k_imm[k], k_ill[k]);
      end
    end
    wait_drain();
  endtask

  task automatic test_all_formats();
    bus32.out_ready_i = 1'b1;
    for (int k = 0; k < 48; k++)
      send($urandom, 4'(k % 16), 5'(k));
    bus32.in_valid_i = 1'b0;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    sending = 1'b1;
    fork
      begin
        for (int k = 0; k < 40; k++)
          send($urandom, 4'($urandom_range(0, 15)), 5'($urandom));
        bus32.in_valid_i = 1'b0;
        sending = 1'b0;
      end
      begin
        while (sending) begin
          @(posedge clk); #1;
          bus32.out_ready_i = 1'($urandom_range(0, 1));
        end
        bus32.out_ready_i = 1'b1;
      end
    join
    bus32.out_ready_i = 1'b1;
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic       accepted;
    logic [4:0] exp_tag;
    bus32.out_ready_i = 1'b0;
    send(32'h00100093, 4'd1, 5'd1);
    send(32'h00200093, 4'd1, 5'd2);
    checks++;
    if (bus32.in_ready_o !== 1'b0) begin
      errors++; $display("FAIL bp_in_ready got %b exp 0", bus32.in_ready_o);
    end
    bus32.insn_i = 32'h00300093; bus32.tag_i = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus32.in_ready_o !== 1'b0 || bus32.out_valid_o !== 1'b1 || bus32.tag_o !== 5'd1) begin
      errors++;
      $display("FAIL bp_hold got rdy=%b v=%b tag=%0d exp rdy=0 v=1 tag=1",
               bus32.in_ready_o, bus32.out_valid_o, bus32.tag_o);
    end
    bus32.out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_tag = 5'(k + 1);
      @(negedge clk);
      accepted = bus32.in_valid_i & bus32.in_ready_o;
      checks++;
      if (bus32.out_valid_o !== 1'b1 || bus32.tag_o !== exp_tag) begin
        errors++;
        $display("FAIL bp_order_%0d got v=%b tag=%0d exp v=1 tag=%0d", k, bus32.out_valid_o, bus32.tag_o, exp_tag);
      end
      @(posedge clk); #1;
      if (accepted) bus32.in_valid_i = 1'b0;
    end
    checks++;
    if (bus32.out_valid_o !== 1'b0 || bus32.in_valid_i !== 1'b0) begin
      errors++;
      $display("FAIL bp_after got v=%b in_valid=%b exp 0 0", bus32.out_valid_o, bus32.in_valid_i);
    end
    wait_drain();
  endtask

  task automatic test_flush();
    bus32.out_ready_i = 1'b0;
    send(32'h00500093, 4'd1, 5'd5);
    send(32'h00600093, 4'd1, 5'd6);
    bus32.insn_i = 32'h00700093; bus32.tag_i = 5'd7;
    bus32.in_valid_i  = 1'b1;
    bus32.out_ready_i = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (bus32.out_valid_o !== 1'b0 || bus32.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_state got v=%b rdy=%b exp v=0 rdy=1", bus32.out_valid_o, bus32.in_ready_o);
    end
    bus32.in_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus32.out_valid_o !== 1'b0) begin
      errors++; $display("FAIL flush_dropped got v=%b tag=%0d exp v=0", bus32.out_valid_o, bus32.tag_o);
    end
  endtask

  task automatic test_reset_mid();
    bus32.out_ready_i = 1'b0;
    send(32'hFFF00093, 4'd1, 5'd9);
    send(32'h00000000, 4'd14, 5'd10);
    bus32.in_valid_i = 1'b0;
    checks++;
    if (bus32.out_valid_o !== 1'b1 || bus32.in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre got v=%b rdy=%b exp v=1 rdy=0", bus32.out_valid_o, bus32.in_ready_o);
    end
    rst = 1'b1;
    bus32.in_valid_i  = 1'b1;
    bus32.out_ready_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus32.in_valid_i = 1'b0;
    checks++;
    if ({bus32.out_valid_o, bus32.imm_o, bus32.tag_o, bus32.illegal_o} !== '0 || bus32.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_outputs got v=%b imm=%h tag=%0d ill=%b rdy=%b exp 0 0 0 0 rdy=1",
               bus32.out_valid_o, bus32.imm_o, bus32.tag_o, bus32.illegal_o, bus32.in_ready_o);
    end
    @(posedge clk); #1;
    checks++;
    if (bus32.out_valid_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_entry got v=%b exp 0", bus32.out_valid_o);
    end
  endtask

  task automatic test_xlen64();
    logic [31:0] x_insn [4] = '{32'hFFF00093, 32'h03F00013, 32'h80000037, 32'h00000000};
    logic [3:0]  x_sel  [4] = '{4'd1, 4'd6, 4'd5, 4'd14};
    logic [63:0] x_imm  [4] = '{64'hFFFFFFFFFFFFFFFF, 64'd63, 64'hFFFFFFFF80000000, 64'd0};
    logic        x_ill  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] r_insn;
    logic [3:0]  r_sel;
    bus64.out_ready_i = 1'b1;
    for (int k = 0; k < 4 + 24; k++) begin
      if (k < 4) begin
        r_insn = x_insn[k]; r_sel = x_sel[k];
      end else begin
        r_insn = $urandom; r_sel = 4'($urandom_range(0, 11));
      end
      bus64.in_valid_i = 1'b1;
      bus64.insn_i     = r_insn;
      bus64.imm_sel_i  = r_sel;
      bus64.tag_i      = 5'(k);
      @(posedge clk); #1;
      bus64.in_valid_i = 1'b0;
      checks++;
      if (k < 4) begin
        if (bus64.out_valid_o !== 1'b1 || bus64.imm_o !== x_imm[k] || bus64.illegal_o !== x_ill[k]) begin
          errors++;
          $display("FAIL x64_known_%0d got v=%b imm=%h ill=%b exp imm=%h ill=%b",
                   k, bus64.out_valid_o, bus64.imm_o, bus64.illegal_o, x_imm[k], x_ill[k]);
        end
      end else if (bus64.out_valid_o !== 1'b1 || bus64.imm_o !== model(r_insn, r_sel, 64) ||
                   bus64.tag_o !== 5'(k)) begin
        errors++;
        $display("FAIL x64_sel%0d got v=%b imm=%h tag=%0d exp imm=%h tag=%0d",
                 r_sel, bus64.out_valid_o, bus64.imm_o, bus64.tag_o, model(r_insn, r_sel, 64), 5'(k));
      end
    end
  endtask

  initial begin
    bus32.in_valid_i = 1'b0; bus32.insn_i = '0; bus32.imm_sel_i = '0;
    bus32.tag_i = '0; bus32.out_ready_i = 1'b0;
    bus64.in_valid_i = 1'b0; bus64.insn_i = '0; bus64.imm_sel_i = '0;
    bus64.tag_i = '0; bus64.out_ready_i = 1'b0;
    sending = 1'b0;
    test_reset();
    test_known_values();
    test_all_formats();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_xlen64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate generator for the decode stage. Decodes the immediate of 32-bit base and 16-bit compressed (RVC) instructions, sign- or zero-extends it to XLEN, and carries a sideband tag. Sits between fetch/decode and the ID/EX boundary behind a valid/ready handshake with a 2-entry skid buffer, giving full throughput under backpressure and single-cycle flush.

## Interface
Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag carried with each immediate (e.g. rd, ROB index).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous discard of all held entries.
- in_valid_i  in  1  upstream entry valid.
- in_ready_o  out  1  stage can accept an entry.
- insn_i  in  32  instruction; RVC instructions occupy insn_i[15:0], upper bits ignored.
- imm_sel_i  in  4  immediate format select.
- tag_i  in  TAG_W  sideband tag.
- out_valid_o  out  1  output entry valid.
- out_ready_i  in  1  downstream accepts.
- imm_o  out  XLEN  extended immediate.
- tag_o  out  TAG_W  tag of output entry.
- illegal_o  out  1  imm_sel_i of this entry was reserved.

## Operation
- imm_sel_i codes; "sext" = sign-extend to XLEN, "zext" = zero-extend to XLEN:
- 0 NONE: 0.
- 1 I: sext insn[31:20].
- 2 S: sext {insn[31:25], insn[11:7]}.
- 3 B: sext {insn[31], insn[7], insn[30:25], insn[11:8], 0}.
- 4 J: sext {insn[31], insn[19:12], insn[20], insn[30:21], 0}.
- 5 U: sext {insn[31:12], 12'b0}; for XLEN=64 bits 63:32 copy insn[31].
- 6 SHIFT: zext insn[24:20] for XLEN=32; zext insn[25:20] for XLEN=64.
- 7 CSR uimm: zext insn[19:15].
- 8 C_CI (c.addi/c.li): sext {insn[12], insn[6:2]}.
- 9 C_LWSP: zext {insn[3:2], insn[12], insn[6:4], 2'b00}.
- 10 C_J: sext {insn[12], insn[8], insn[10:9], insn[6], insn[7], insn[2], insn[11], insn[5:3], 0}.
- 11 C_B (c.beqz/c.bnez): sext {insn[12], insn[6:5], insn[2], insn[11:10], insn[4:3], 0}.
- 12-15 reserved: imm_o = 0, illegal_o = 1. All other codes: illegal_o = 0.
- Decode is combinational on the input side; the stored entry is {imm, tag, illegal}.
- Storage: output register (OUT) plus skid register (SKID). in_ready_o = ~SKID valid, driven from a register.
- Accept when in_valid_i & in_ready_o. Accepted entry goes to OUT if OUT is empty or draining in the same cycle (out_ready_i=1); otherwise it goes to SKID.
- On OUT drain with SKID valid: SKID moves to OUT. If a new entry is also accepted in that cycle, the new entry goes to SKID.
- Order is strictly FIFO.
- Contents of imm_o/tag_o/illegal_o hold stable while out_valid_o & ~out_ready_i.

## Timing
- Latency: accept in cycle N -> out_valid_o in cycle N+1 when OUT was empty or draining.
- Throughput: 1 entry/cycle while out_ready_i=1.
- in_ready_o falls the cycle after an entry lands in SKID and rises the cycle after SKID empties. An in_valid_i held while in_ready_o=0 is not consumed.
- flush_i: OUT and SKID become invalid next cycle. Any input offered in the flush cycle is dropped. out_ready_i in that cycle has no effect. in_ready_o=1 next cycle.
- rst_i (including mid-transfer): out_valid_o=0, imm_o=0, tag_o=0, illegal_o=0, SKID invalid next cycle. in_ready_o=1 from the first cycle after reset. Handshakes in reset cycles are ignored. rst_i has priority over flush_i.
- No combinational path from out_ready_i to in_ready_o.

## Test plan
- XLEN=32, I, insn 0xFFF00093 -> next cycle imm_o=0xFFFFFFFF. With XLEN=64 -> 0xFFFFFFFFFFFFFFFF.
- B, insn 0xFE000EE3 (beq -4) -> imm_o=0xFFFFFFFC. SHIFT with XLEN=64, insn[25:20]=0x3F -> imm_o=63.
- RVC: C_CI insn 0x00001FFD -> 0xFFFFFFFF. C_LWSP insn 0x000050FE -> 0x000000FC. sel 13 -> imm_o=0, illegal_o=1.
- Backpressure: out_ready_i=0, push tags 1,2 on consecutive cycles -> in_ready_o=0 after 2nd accept, tag 3 held upstream. Raise out_ready_i -> tags 1,2,3 emitted on consecutive cycles, no loss or duplicate.
- Flush with OUT and SKID full plus input offered -> out_valid_o=0 and in_ready_o=1 next cycle; offered entry never appears.
- Reset asserted while out_valid_o=1 and in_ready_o=0 -> all outputs 0 next cycle, in_ready_o=1 after release.
